// File: rtl/sram_like_arbiter.sv
// Two-to-one SRAM-like arbiter: instruction fetch and data access share one master port.
// Data has priority; a starvation counter guarantees instruction fetch makes progress.
module sram_like_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        m_req,
    output logic        m_wr,
    output logic [1:0]  m_size,
    output logic [3:0]  m_wen,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_addr_ok,
    input  logic        m_data_ok,
    output logic        busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t             state;
    logic               gnt;        // 0 = inst owns the port, 1 = data
    logic [CNT_W-1:0]   starve_cnt;

    logic arb_point;
    logic pick_data;
    logic pick_inst;
    logic owner_req;
    logic in_addr;
    logic in_data;

    assign arb_point = (state == IDLE) || ((state == DATA) && m_data_ok);
    assign pick_data = data_req && (!inst_req || (starve_cnt < LIMIT));
    assign pick_inst = !pick_data && inst_req;
    assign owner_req = gnt ? data_req : inst_req;

    // State, owner and starvation tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= 1'b0;
            starve_cnt <= '0;
        end else begin
            case (state)
                IDLE, DATA: begin
                    if (arb_point) begin
                        if (pick_data) begin
                            gnt   <= 1'b1;
                            state <= ADDR;
                        end else if (pick_inst) begin
                            gnt   <= 1'b0;
                            state <= ADDR;
                        end else begin
                            state <= IDLE;
                        end
                        if (!inst_req || pick_inst) begin
                            starve_cnt <= '0;
                        end else if (pick_data && (starve_cnt < LIMIT)) begin
                            starve_cnt <= starve_cnt + CNT_W'(1);
                        end
                    end
                end
                ADDR: begin
                    // An owner that drops req before acceptance forfeits the slot
                    if (!owner_req) begin
                        state <= IDLE;
                    end else if (m_addr_ok) begin
                        state <= DATA;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshakes are forced low while reset is held, even before the state clears
    assign in_addr = !rst && (state == ADDR);
    assign in_data = !rst && (state == DATA);

    assign m_req   = in_addr && owner_req;
    assign m_wr    = gnt ? data_wr    : inst_wr;
    assign m_size  = gnt ? data_size  : inst_size;
    assign m_addr  = gnt ? data_addr  : inst_addr;
    assign m_wdata = gnt ? data_wdata : inst_wdata;
    assign m_wen   = !in_addr ? 4'b0000 : (gnt ? data_wen : {4{inst_wr}});

    assign inst_addr_ok = m_req && !gnt && m_addr_ok;
    assign data_addr_ok = m_req &&  gnt && m_addr_ok;
    assign inst_data_ok = in_data && !gnt && m_data_ok;
    assign data_data_ok = in_data &&  gnt && m_data_ok;

    assign inst_rdata = m_rdata;
    assign data_rdata = m_rdata;
    assign busy       = !rst && (state != IDLE);

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Randomized scoreboard bench for sram_like_arbiter: a reference model queues expected
// handshakes per cycle, a negedge monitor pops and compares whatever the DUT presents.
module tb_sram_like_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]  inst_size = 2'd0;
    logic [31:0] inst_addr = 32'd0, inst_wdata = 32'd0;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [3:0]  data_wen = 4'd0;
    logic [31:0] data_addr = 32'd0, data_wdata = 32'd0;
    logic [31:0] m_rdata = 32'd0;
    logic        m_addr_ok = 1'b0, m_data_ok = 1'b0;

    logic [31:0] inst_rdata, data_rdata, m_addr, m_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        m_req, m_wr, busy;
    logic [1:0]  m_size;
    logic [3:0]  m_wen;

    sram_like_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wen(m_wen),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .busy(busy)
    );

    always #5 clk = ~clk;

    // kind: 0 m_req, 1 inst_addr_ok, 2 data_addr_ok, 3 inst_data_ok, 4 data_data_ok
    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wen;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] rdata;
    } ev_t;

    ev_t evq[$];
    int  glog[$];
    bit  log_en = 1'b0;
    bit  mon_en = 1'b0;
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    // Transaction-level reference state
    int  phase = 0;      // 0 idle, 1 address offered, 2 waiting for completion
    int  owner = 0;      // 0 inst, 1 data
    int  consec = 0;     // data grants in a row while inst has been waiting
    bit  inst_acc = 1'b0, data_acc = 1'b0;
    bit  exp_busy = 1'b0;

    logic [31:0] last_inst_rdata = 32'd0;
    int          last_inst_dok_cyc = -1;
    int          last_inst_aok_cyc = -1;

    function automatic void push_ev(int k);
        ev_t e;
        e.cyc = cyc;
        e.kind = k;
        e.rdata = m_rdata;
        if (owner == 1) begin
            e.addr = data_addr; e.wdata = data_wdata; e.wen = data_wen;
            e.wr = data_wr; e.size = data_size;
        end else begin
            e.addr = inst_addr; e.wdata = inst_wdata; e.wen = inst_wr ? 4'hF : 4'h0;
            e.wr = inst_wr; e.size = inst_size;
        end
        evq.push_back(e);
    endfunction

    function automatic void choose();
        if (data_req && (!inst_req || consec < int'(LIMIT))) begin
            owner = 1;
            consec = inst_req ? consec + 1 : 0;
            phase = 1;
        end else if (inst_req) begin
            owner = 0;
            consec = 0;
            phase = 1;
        end else begin
            consec = 0;
            phase = 0;
        end
    endfunction

    function automatic void model_eval();
        bit oreq;
        inst_acc = 1'b0;
        data_acc = 1'b0;
        if (rst) begin
            exp_busy = 1'b0; phase = 0; owner = 0; consec = 0;
            return;
        end
        exp_busy = (phase != 0);
        case (phase)
            1: begin
                oreq = (owner == 1) ? data_req : inst_req;
                if (!oreq) begin
                    phase = 0;
                end else begin
                    push_ev(0);
                    if (m_addr_ok) begin
                        push_ev(1 + owner);
                        if (owner == 1) data_acc = 1'b1; else inst_acc = 1'b1;
                        phase = 2;
                    end
                end
            end
            2: if (m_data_ok) begin
                push_ev(3 + owner);
                choose();
            end
            default: choose();
        endcase
    endfunction

    task automatic check_ev(input int k, input logic pres);
        int idx;
        logic [31:0] got_rd;
        if (pres === 1'b0) return;
        idx = -1;
        for (int i = 0; i < evq.size(); i++) begin
            if (evq[i].cyc > cyc) break;
            if (evq[i].cyc == cyc && evq[i].kind == k) begin idx = i; break; end
        end
        checks++;
        if (idx < 0) begin
            errors++;
            $display("FAIL spurious_event kind=%0d cycle=%0d got=%b required=0", k, cyc, pres);
            return;
        end
        if (k == 0) begin
            if (m_addr !== evq[idx].addr || m_wdata !== evq[idx].wdata || m_wen !== evq[idx].wen ||
                m_wr !== evq[idx].wr || m_size !== evq[idx].size) begin
                errors++;
                $display("FAIL m_fields cycle=%0d got addr=%h wdata=%h wen=%b wr=%b size=%0d required addr=%h wdata=%h wen=%b wr=%b size=%0d",
                         cyc, m_addr, m_wdata, m_wen, m_wr, m_size, evq[idx].addr, evq[idx].wdata,
                         evq[idx].wen, evq[idx].wr, evq[idx].size);
            end
        end else if (k >= 3) begin
            got_rd = (k == 3) ? inst_rdata : data_rdata;
            if (got_rd !== evq[idx].rdata) begin
                errors++;
                $display("FAIL rdata kind=%0d cycle=%0d got=%h required=%h", k, cyc, got_rd, evq[idx].rdata);
            end
            if (k == 3) begin last_inst_rdata = got_rd; last_inst_dok_cyc = cyc; end
        end else begin
            if (log_en) glog.push_back(k - 1);
            if (k == 1) last_inst_aok_cyc = cyc;
        end
        evq.delete(idx);
    endtask

    // Monitor: compare everything the DUT shows against the queued expectations
    always @(negedge clk) begin
        if (mon_en) begin
            check_ev(0, m_req);
            check_ev(1, inst_addr_ok);
            check_ev(2, data_addr_ok);
            check_ev(3, inst_data_ok);
            check_ev(4, data_data_ok);
            while (evq.size() > 0 && evq[0].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_event kind=%0d cycle=%0d got=0 required=1", evq[0].kind, evq[0].cyc);
                void'(evq.pop_front());
            end
            checks++;
            if (busy !== exp_busy) begin
                errors++;
                $display("FAIL busy cycle=%0d got=%b required=%b", cyc, busy, exp_busy);
            end
            if (!exp_busy) begin
                checks++;
                if (m_wen !== 4'b0000) begin
                    errors++;
                    $display("FAIL idle_wen cycle=%0d got=%b required=0000", cyc, m_wen);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic new_inst();
        inst_req = 1'b1;
        inst_wr = ($urandom_range(0, 9) == 0);
        inst_size = 2'($urandom_range(0, 2));
        inst_addr = $urandom() & 32'hFFFF_FFFC;
        inst_wdata = $urandom();
    endtask

    task automatic new_data();
        data_req = 1'b1;
        data_wr = 1'($urandom_range(0, 1));
        data_size = 2'($urandom_range(0, 2));
        data_wen = 4'($urandom_range(0, 15));
        data_addr = $urandom();
        data_wdata = $urandom();
    endtask

    task automatic run_cycles(input int n, input int p_req, input int p_aok, input int p_dok,
                              input bit abort_en, input bit rst_en);
        for (int i = 0; i < n; i++) begin
            tick();
            if (inst_acc) inst_req = 1'b0;
            if (data_acc) data_req = 1'b0;
            if (!inst_req && $urandom_range(0, 99) < p_req) new_inst();
            if (!data_req && $urandom_range(0, 99) < p_req) new_data();
            if (abort_en && data_req && $urandom_range(0, 99) < 3) data_req = 1'b0;
            m_addr_ok = ($urandom_range(0, 99) < p_aok);
            m_data_ok = ($urandom_range(0, 99) < p_dok);
            m_rdata = $urandom();
            rst = rst_en && ($urandom_range(0, 99) < 2);
            model_eval();
        end
    endtask

    task automatic expect_int(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    initial begin
        int t0;
        model_eval();
        tick(); model_eval();
        mon_en = 1'b1;
        tick(); model_eval();
        tick(); rst = 1'b0; model_eval();

        // Single instruction read
        tick(); t0 = cyc; inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2;
        inst_addr = 32'hBFC0_0000; inst_wdata = 32'd0; model_eval();
        tick(); model_eval();
        tick(); m_addr_ok = 1'b1; model_eval();
        tick(); m_addr_ok = 1'b0; inst_req = 1'b0; model_eval();
        tick(); m_data_ok = 1'b1; m_rdata = 32'h3C08_0001; model_eval();
        tick(); m_data_ok = 1'b0; model_eval();
        expect_int("inst_read_addr_ok_cycle", last_inst_aok_cyc - t0, 2);
        expect_int("inst_read_data_ok_cycle", last_inst_dok_cyc - t0, 4);
        checks++;
        if (last_inst_rdata !== 32'h3C08_0001) begin
            errors++;
            $display("FAIL inst_read_rdata got=%h required=3c080001", last_inst_rdata);
        end

        // Simultaneous requests: data write goes first
        run_cycles(4, 0, 100, 100, 1'b0, 1'b0);
        glog.delete();
        log_en = 1'b1;
        tick(); inst_req = 1'b1; inst_wr = 1'b0; inst_addr = 32'hBFC0_0004;
        data_req = 1'b1; data_wr = 1'b1; data_wen = 4'b0011; data_size = 2'd2;
        data_addr = 32'h8000_0010; data_wdata = 32'hCAFE_F00D; m_addr_ok = 1'b0; model_eval();
        tick(); m_addr_ok = 1'b1; model_eval();
        tick(); m_addr_ok = 1'b0; data_req = 1'b0; m_data_ok = 1'b1; model_eval();
        tick(); m_data_ok = 1'b0; m_addr_ok = 1'b1; model_eval();
        tick(); m_addr_ok = 1'b0; inst_req = 1'b0; m_data_ok = 1'b1; model_eval();
        tick(); m_data_ok = 1'b0; model_eval();
        log_en = 1'b0;
        expect_int("simul_grant_count", glog.size(), 2);
        if (glog.size() == 2) begin
            expect_int("simul_first_owner", glog[0], 1);
            expect_int("simul_second_owner", glog[1], 0);
        end

        // Starvation: both requesters saturate the port
        run_cycles(6, 0, 100, 100, 1'b0, 1'b0);
        glog.delete();
        log_en = 1'b1;
        run_cycles(26, 100, 100, 100, 1'b0, 1'b0);
        log_en = 1'b0;
        run_cycles(6, 0, 100, 100, 1'b0, 1'b0);
        expect_int("starve_grant_count_min", (glog.size() >= 10) ? 1 : 0, 1);
        for (int i = 0; i < 10 && i < glog.size(); i++)
            expect_int($sformatf("starve_owner_%0d", i), glog[i], (i % 5 == 4) ? 0 : 1);

        // Delayed accept with a stray completion during the address phase
        tick(); data_req = 1'b1; data_wr = 1'b0; data_wen = 4'b0000; data_size = 2'd2;
        data_addr = 32'h8000_1000; inst_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0; model_eval();
        for (int i = 0; i < 5; i++) begin
            tick(); m_addr_ok = 1'b0; m_data_ok = (i == 2); m_rdata = 32'hDEAD_0000 + 32'(i); model_eval();
        end
        tick(); m_addr_ok = 1'b1; m_data_ok = 1'b0; model_eval();
        tick(); m_addr_ok = 1'b0; data_req = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h1234_5678; model_eval();
        tick(); m_data_ok = 1'b0; model_eval();

        // Reset while waiting for completion; late completion must be dropped
        tick(); inst_req = 1'b1; inst_addr = 32'hBFC0_0100; model_eval();
        tick(); model_eval();
        tick(); m_addr_ok = 1'b1; model_eval();
        tick(); m_addr_ok = 1'b0; inst_req = 1'b0; model_eval();
        tick(); rst = 1'b1; model_eval();
        tick(); rst = 1'b0; model_eval();
        tick(); m_data_ok = 1'b1; m_rdata = 32'hBAD0_BAD0; model_eval();
        tick(); m_data_ok = 1'b0; model_eval();

        // Data requester aborts in the address phase; inst follows
        tick(); t0 = cyc; inst_req = 1'b1; inst_addr = 32'hBFC0_0200; inst_wr = 1'b0;
        data_req = 1'b1; data_addr = 32'h8000_2000; model_eval();
        tick(); model_eval();
        tick(); data_req = 1'b0; model_eval();
        tick(); model_eval();
        tick(); m_addr_ok = 1'b1; model_eval();
        tick(); m_addr_ok = 1'b0; inst_req = 1'b0; m_data_ok = 1'b1; model_eval();
        tick(); m_data_ok = 1'b0; model_eval();
        expect_int("abort_inst_accept_cycle", last_inst_aok_cyc - t0, 4);

        // Randomized traffic with aborts and occasional reset
        run_cycles(3000, 40, 50, 50, 1'b1, 1'b1);
        run_cycles(30, 0, 100, 100, 1'b0, 1'b0);
        tick(); model_eval();
        @(negedge clk);
        #1;
        expect_int("leftover_events", evq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
